// File: rtl/instruction_cycle_pkg.sv
// Shared definitions for the instruction-cycle controller: opcodes, state codes
// and accumulator source selects.
package instruction_cycle_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ADDSUB = 2'b00;
    localparam logic [1:0] ASEL_INPUT  = 2'b01;
    localparam logic [1:0] ASEL_RAM    = 2'b10;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    function automatic state_e decode_op(input logic [2:0] op);
        state_e s;
        case (op)
            OP_LOAD:  s = S_LOAD;
            OP_STORE: s = S_STORE;
            OP_ADD:   s = S_ADD;
            OP_SUB:   s = S_SUB;
            OP_IN:    s = S_INPUT;
            OP_JZ:    s = S_JZ;
            OP_JPOS:  s = S_JPOS;
            default:  s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/instruction_cycle_ctrl.sv
// Fetch/decode/execute sequencer for the PC/IR/RAM/accumulator datapath,
// with a retired-instruction counter and a debug view of the state.
module instruction_cycle_ctrl
    import instruction_cycle_pkg::*;
#(
    parameter int OPW  = 3,
    parameter int CNTW = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [OPW-1:0]  IR,
    input  logic            Aeq0,
    input  logic            Apos,
    input  logic            Enter,
    output logic            IRload,
    output logic            JMPmux,
    output logic            PCload,
    output logic            Meminst,
    output logic            MemWr,
    output logic [1:0]      Asel,
    output logic            Aload,
    output logic            Sub,
    output logic            Halt,
    output logic [CNTW-1:0] InstrCount,
    output logic [3:0]      State
);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              retire;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on the registered state plus Aeq0/Apos/Enter.
    always_comb begin
        state_d = S_START;
        retire  = 1'b0;
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ADDSUB;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                Meminst = 1'b1;
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = decode_op(IR[2:0]);
            S_LOAD: begin
                Asel    = ASEL_RAM;
                Aload   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_STORE: begin
                MemWr   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADD, S_SUB: begin
                Asel    = ASEL_ADDSUB;
                Sub     = (state_q == S_SUB);
                Aload   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_INPUT: begin
                Asel    = ASEL_INPUT;
                Aload   = Enter;
                retire  = Enter;
                state_d = Enter ? S_FETCH : S_INPUT;
            end
            S_JZ, S_JPOS: begin
                // Not-taken jumps still retire; PC simply keeps PC+1 from FETCH.
                JMPmux  = 1'b1;
                PCload  = (state_q == S_JZ) ? Aeq0 : Apos;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                Halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_START;
        endcase
        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, retire};
    end

    assign InstrCount = cnt_q;
    assign State      = state_q;

endmodule

// File: tb/tb_instruction_cycle_ctrl.sv
// Scoreboard bench for instruction_cycle_ctrl: each driven cycle queues the
// expected state/controls/count, and a negedge monitor pops and compares.
module tb_instruction_cycle_ctrl;
    import instruction_cycle_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  IR;
    logic        Aeq0, Apos, Enter;
    logic        IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0]  Asel;
    logic [15:0] InstrCount;
    logic [3:0]  State;

    instruction_cycle_ctrl #(.OPW(3), .CNTW(16)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
        .Enter(Enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
        .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
        .Sub(Sub), .Halt(Halt), .InstrCount(InstrCount), .State(State)
    );

    always #5 Clock = ~Clock;

    // {IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt}
    localparam logic [9:0] C_ZERO  = 10'b0_0_0_0_0_00_0_0_0;
    localparam logic [9:0] C_FETCH = 10'b1_0_1_1_0_00_0_0_0;
    localparam logic [9:0] C_LOAD  = 10'b0_0_0_0_0_10_1_0_0;
    localparam logic [9:0] C_STORE = 10'b0_0_0_0_1_00_0_0_0;
    localparam logic [9:0] C_ADD   = 10'b0_0_0_0_0_00_1_0_0;
    localparam logic [9:0] C_SUB   = 10'b0_0_0_0_0_00_1_1_0;
    localparam logic [9:0] C_INW   = 10'b0_0_0_0_0_01_0_0_0;
    localparam logic [9:0] C_INGO  = 10'b0_0_0_0_0_01_1_0_0;
    localparam logic [9:0] C_JT    = 10'b0_1_1_0_0_00_0_0_0;
    localparam logic [9:0] C_JN    = 10'b0_1_0_0_0_00_0_0_0;
    localparam logic [9:0] C_HALT  = 10'b0_0_0_0_0_00_0_0_1;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [9:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_state"}, 32'(State), 32'(e.st));
            chk({e.tag, "_ctrl"},
                32'({IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt}),
                32'(e.ctrl));
            chk({e.tag, "_cnt"}, 32'(InstrCount), 32'(e.cnt));
        end
    end

    task automatic push_exp(input string tag, input logic [3:0] st, input logic [9:0] ctrl);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = ctrl;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    // Called just after a rising edge: drive inputs, queue this cycle's expectation.
    task automatic cyc(input string tag, input logic [2:0] ir, input logic a0,
                       input logic ap, input logic en, input logic [3:0] st,
                       input logic [9:0] ctrl, input bit ret);
        IR = ir; Aeq0 = a0; Apos = ap; Enter = en;
        push_exp(tag, st, ctrl);
        if (ret) exp_cnt++;
        @(posedge Clock);
        #1;
    endtask

    task automatic front(input string tag, input logic [2:0] ir, input logic a0,
                         input logic ap, input logic en);
        cyc({tag, "_fetch"},  ir, a0, ap, en, S_FETCH,  C_FETCH, 1'b0);
        cyc({tag, "_decode"}, ir, a0, ap, en, S_DECODE, C_ZERO,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; IR = '0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
        @(posedge Clock);
        #1;
        cyc("rst0", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);
        cyc("rst1", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);
        Reset = 1'b1;
        cyc("start", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);

        front("load", OP_LOAD, 1'b0, 1'b0, 1'b0);
        cyc("load_ex", OP_LOAD, 1'b0, 1'b0, 1'b0, S_LOAD, C_LOAD, 1'b1);
        front("add", OP_ADD, 1'b0, 1'b0, 1'b0);
        cyc("add_ex", OP_ADD, 1'b0, 1'b0, 1'b0, S_ADD, C_ADD, 1'b1);
        front("sub", OP_SUB, 1'b0, 1'b0, 1'b0);
        cyc("sub_ex", OP_SUB, 1'b0, 1'b0, 1'b0, S_SUB, C_SUB, 1'b1);

        front("in", OP_IN, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc("in_wait", OP_IN, 1'b0, 1'b0, 1'b0, S_INPUT, C_INW, 1'b0);
        cyc("in_go", OP_IN, 1'b0, 1'b0, 1'b1, S_INPUT, C_INGO, 1'b1);

        front("jz_t", OP_JZ, 1'b1, 1'b0, 1'b0);
        cyc("jz_t_ex", OP_JZ, 1'b1, 1'b0, 1'b0, S_JZ, C_JT, 1'b1);
        front("jz_n", OP_JZ, 1'b0, 1'b1, 1'b0);
        cyc("jz_n_ex", OP_JZ, 1'b0, 1'b1, 1'b0, S_JZ, C_JN, 1'b1);
        front("jp_t", OP_JPOS, 1'b0, 1'b1, 1'b0);
        cyc("jp_t_ex", OP_JPOS, 1'b0, 1'b1, 1'b0, S_JPOS, C_JT, 1'b1);
        front("jp_n", OP_JPOS, 1'b1, 1'b0, 1'b0);
        cyc("jp_n_ex", OP_JPOS, 1'b1, 1'b0, 1'b0, S_JPOS, C_JN, 1'b1);

        // Asynchronous reset in the middle of a STORE cycle.
        front("store", OP_STORE, 1'b0, 1'b0, 1'b0);
        IR = OP_STORE;
        push_exp("store_ex", S_STORE, C_STORE);
        #5;
        Reset = 1'b0;
        #1;
        chk("store_abort_memwr", 32'(MemWr), 32'd0);
        chk("store_abort_state", 32'(State), 32'(S_START));
        chk("store_abort_cnt", 32'(InstrCount), 32'd0);
        exp_cnt = '0;
        @(posedge Clock);
        #1;
        cyc("rst_hold", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);
        Reset = 1'b1;
        cyc("restart", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);

        front("add2", OP_ADD, 1'b0, 1'b0, 1'b0);
        cyc("add2_ex", OP_ADD, 1'b0, 1'b0, 1'b0, S_ADD, C_ADD, 1'b1);
        front("halt", OP_HALT, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc("halt_hold", OP_HALT, 1'b1, 1'b1, 1'b1, S_HALT, C_HALT, 1'b0);

        Reset = 1'b0;
        exp_cnt = '0;
        cyc("halt_rst", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);
        Reset = 1'b1;
        cyc("halt_restart", 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO, 1'b0);
        cyc("post_fetch", 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH, 1'b0);

        @(negedge Clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
